// File: rtl/pwm_update_scheduler.sv
// PWM output stage with double-buffered configuration.
// Deferred updates are held in a pending set and committed at the period boundary.
// Immediate updates load the active set directly and restart the period.
module pwm_update_scheduler #(
  parameter int unsigned PRESCALE = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  input  logic        cfg_immediate,
  input  logic [15:0] en_out_in,
  input  logic [15:0] en_pwm_in,
  input  logic [7:0]  duty_in,
  output logic [15:0] uo_out,
  output logic        cfg_ack,
  output logic        cfg_pending,
  output logic        period_start
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_presc;
  logic [7:0]  r_cnt;
  logic [15:0] r_pend_en_out;
  logic [15:0] r_pend_en_pwm;
  logic [7:0]  r_pend_duty;
  logic [15:0] r_act_en_out;
  logic [15:0] r_act_en_pwm;
  logic [7:0]  r_act_duty;
  logic        r_ack;
  logic        r_period_start;

  logic w_tick;
  logic w_bnd;
  logic w_imm;
  logic w_defer;
  logic w_load_pend;
  logic w_commit_pend;
  logic w_commit_in;
  logic w_level;

  assign w_tick  = (r_presc == PS_MAX);
  assign w_bnd   = w_tick && (r_cnt == 8'hFF);
  assign w_imm   = cfg_valid && cfg_immediate;
  assign w_defer = cfg_valid && !cfg_immediate;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and commit decisions; immediate requests override everything
  always_comb begin
    w_state_nxt   = r_state;
    w_load_pend   = 1'b0;
    w_commit_pend = 1'b0;
    w_commit_in   = 1'b0;
    if (w_imm) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_defer) begin
            w_load_pend = 1'b1;
            w_state_nxt = PENDING;
          end
        end
        PENDING: begin
          if (w_bnd) begin
            w_state_nxt = IDLE;
            // A request arriving on the boundary itself supersedes the older pending set
            if (w_defer) w_commit_in   = 1'b1;
            else         w_commit_pend = 1'b1;
          end else if (w_defer) begin
            w_load_pend = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Prescaler and PWM counter; an immediate commit restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_imm) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_cnt   <= r_cnt + 8'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Pending configuration capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_en_out <= '0;
      r_pend_en_pwm <= '0;
      r_pend_duty   <= '0;
    end else if (w_load_pend) begin
      r_pend_en_out <= en_out_in;
      r_pend_en_pwm <= en_pwm_in;
      r_pend_duty   <= duty_in;
    end
  end

  // Active configuration update from inputs or from the pending set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_en_out <= '0;
      r_act_en_pwm <= '0;
      r_act_duty   <= '0;
    end else if (w_imm || w_commit_in) begin
      r_act_en_out <= en_out_in;
      r_act_en_pwm <= en_pwm_in;
      r_act_duty   <= duty_in;
    end else if (w_commit_pend) begin
      r_act_en_out <= r_pend_en_out;
      r_act_en_pwm <= r_pend_en_pwm;
      r_act_duty   <= r_pend_duty;
    end
  end

  // Status pulses: acknowledge and period start, one cycle after the event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_ack          <= w_imm || w_commit_pend || w_commit_in;
      r_period_start <= w_imm || w_bnd;
    end
  end

  // Output decode from registered counter and active set
  always_comb begin
    w_level = (r_act_duty == 8'hFF) ? 1'b1 : (r_cnt < r_act_duty);
    uo_out  = r_act_en_out & (~r_act_en_pwm | {16{w_level}});
  end

  assign cfg_ack      = r_ack;
  assign cfg_pending  = (r_state == PENDING);
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Testbench for pwm_update_scheduler: time-based reference model plus directed scenarios.
module tb_pwm_update_scheduler;

  localparam int P   = 2;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_immediate = 1'b0;
  logic [15:0] en_out_in = '0;
  logic [15:0] en_pwm_in = '0;
  logic [7:0]  duty_in = '0;
  logic [15:0] uo_out;
  logic        cfg_ack;
  logic        cfg_pending;
  logic        period_start;

  pwm_update_scheduler #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_immediate(cfg_immediate),
    .en_out_in(en_out_in), .en_pwm_in(en_pwm_in), .duty_in(duty_in),
    .uo_out(uo_out), .cfg_ack(cfg_ack), .cfg_pending(cfg_pending), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t is clk cycles elapsed since the current period origin
  int          m_t = 0;
  logic        m_pend = 1'b0;
  logic [15:0] m_p_eo = '0, m_p_ep = '0;
  logic [7:0]  m_p_d = '0;
  logic [15:0] m_a_eo = '0, m_a_ep = '0;
  logic [7:0]  m_a_d = '0;
  logic        m_ack = 1'b0, m_ps = 1'b0;
  logic        m_bnd;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_pend = 0; m_ack = 0; m_ps = 0;
        m_p_eo = '0; m_p_ep = '0; m_p_d = '0;
        m_a_eo = '0; m_a_ep = '0; m_a_d = '0;
      end else begin
        m_bnd = (((m_t + 1) % PER) == 0);
        m_ack = 0;
        m_ps  = 0;
        if (cfg_valid && cfg_immediate) begin
          m_a_eo = en_out_in; m_a_ep = en_pwm_in; m_a_d = duty_in;
          m_pend = 0; m_ack = 1; m_ps = 1; m_t = 0;
        end else begin
          if (m_bnd && m_pend) begin
            if (cfg_valid) begin
              m_a_eo = en_out_in; m_a_ep = en_pwm_in; m_a_d = duty_in;
            end else begin
              m_a_eo = m_p_eo; m_a_ep = m_p_ep; m_a_d = m_p_d;
            end
            m_pend = 0;
            m_ack  = 1;
          end else if (cfg_valid) begin
            m_p_eo = en_out_in; m_p_ep = en_pwm_in; m_p_d = duty_in;
            m_pend = 1;
          end
          if (m_bnd) m_ps = 1;
          m_t = (m_t + 1) % PER;
        end
      end
    end
  end

  function automatic logic [15:0] exp_uo();
    int cnt;
    logic lvl;
    logic [15:0] r;
    cnt = (m_t / P) % 256;
    lvl = (m_a_d == 8'hFF) || (cnt < int'(m_a_d));
    for (int i = 0; i < 16; i++) begin
      if (!m_a_eo[i])     r[i] = 1'b0;
      else if (m_a_ep[i]) r[i] = lvl;
      else                r[i] = 1'b1;
    end
    return r;
  endfunction

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("model_uo_out", uo_out, exp_uo());
      chk("model_cfg_ack", cfg_ack, m_ack);
      chk("model_cfg_pending", cfg_pending, m_pend);
      chk("model_period_start", period_start, m_ps);
    end
  end

  task automatic send(input logic imm, input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_immediate = imm;
    en_out_in = eo; en_pwm_in = ep; duty_in = d;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_immediate = 1'b0;
  endtask

  int hi, acks, bad, n;
  logic [15:0] exp;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_uo", uo_out, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_period_start", period_start, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Immediate commit, duty 0x80
    send(1'b1, 16'h0001, 16'h0001, 8'h80);
    chk("imm_ack", cfg_ack, 1);
    chk("imm_period_start", period_start, 1);
    hi = 0;
    repeat (PER) begin hi += int'(uo_out[0]); @(negedge clk); end
    chk("duty80_high_cycles", hi, 256);

    // Deferred commit sent at pwm_cnt 10
    repeat (19) @(negedge clk);
    send(1'b0, 16'h0001, 16'h0001, 8'h40);
    chk("defer_pending", cfg_pending, 1);
    chk("defer_no_ack", cfg_ack, 0);
    acks = 0; bad = 0; n = 0;
    while (!period_start && n < 600) begin
      acks += int'(cfg_ack);
      if (cfg_pending !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    chk("defer_latency", n, 491);
    chk("defer_pending_held", bad, 0);
    hi = 0;
    repeat (PER) begin hi += int'(uo_out[0]); acks += int'(cfg_ack); @(negedge clk); end
    chk("duty40_high_cycles", hi, 128);
    chk("defer_ack_once", acks, 1);

    // Duty extremes on all outputs
    send(1'b1, 16'hFFFF, 16'hFFFF, 8'h00);
    bad = 0;
    repeat (600) begin if (uo_out !== 16'h0000) bad++; @(negedge clk); end
    chk("duty00_constant_low", bad, 0);
    send(1'b1, 16'hFFFF, 16'hFFFF, 8'hFF);
    bad = 0;
    repeat (600) begin if (uo_out !== 16'hFFFF) bad++; @(negedge clk); end
    chk("dutyFF_constant_high", bad, 0);

    // Two deferred configs in one period, the second on the boundary cycle
    send(1'b1, 16'h0001, 16'h0001, 8'h08);
    send(1'b0, 16'h0001, 16'h0001, 8'h10);
    chk("dbl_first_pending", cfg_pending, 1);
    acks = 0;
    repeat (508) begin acks += int'(cfg_ack); @(negedge clk); end
    send(1'b0, 16'h0001, 16'h0001, 8'h20);
    chk("dbl_ack", cfg_ack, 1);
    chk("dbl_period_start", period_start, 1);
    chk("dbl_pending_clear", cfg_pending, 0);
    hi = 0;
    repeat (PER) begin hi += int'(uo_out[0]); acks += int'(cfg_ack); @(negedge clk); end
    chk("duty20_high_cycles", hi, 64);
    chk("dbl_ack_once", acks, 1);

    // Mixed enables: constant-high and PWM lanes
    send(1'b1, 16'hF00F, 16'h000F, 8'h80);
    bad = 0;
    for (int t = 0; t < PER; t++) begin
      exp = 16'hF000 | ((t < 256) ? 16'h000F : 16'h0000);
      if (uo_out !== exp) bad++;
      @(negedge clk);
    end
    chk("mixed_enable_pattern", bad, 0);

    // Reset while pending
    repeat (30) @(negedge clk);
    send(1'b0, 16'hFFFF, 16'hFFFF, 8'hFF);
    chk("rstpend_pending", cfg_pending, 1);
    rst_n = 1'b0;
    #1;
    chk("rstpend_uo", uo_out, 0);
    chk("rstpend_pending_clr", cfg_pending, 0);
    chk("rstpend_ack", cfg_ack, 0);
    chk("rstpend_period_start", period_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    acks = 0; bad = 0;
    repeat (PER + 50) begin
      acks += int'(cfg_ack);
      if (uo_out !== 16'h0000) bad++;
      @(negedge clk);
    end
    chk("rstpend_no_ack", acks, 0);
    chk("rstpend_uo_zero", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_update_scheduler.md
PWM_UPDATE_SCHEDULER -- requirements
Module: pwm_update_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE, default 3000, meaning clk cycles per PWM count step (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_valid  input  1  one-cycle pulse: config inputs below hold a new configuration.
REQ-005 SHALL have port cfg_immediate  input  1  qualifier sampled with cfg_valid: commit now and restart the period.
REQ-006 SHALL have port en_out_in  input  16  output-enable bits {15_8, 7_0}.
REQ-007 SHALL have port en_pwm_in  input  16  PWM-mode bits {15_8, 7_0}.
REQ-008 SHALL have port duty_in  input  8  PWM duty cycle.
REQ-009 SHALL have port uo_out  output  16  driven outputs.
REQ-010 SHALL have port cfg_ack  output  1  one-cycle pulse on the edge after a commit.
REQ-011 SHALL have port cfg_pending  output  1  high while a captured configuration awaits commit.
REQ-012 SHALL have port period_start  output  1  one-cycle pulse on the cycle pwm_cnt first reads 0 of a period.

Function
REQ-013 SHALL hold two register sets, pending and active, each containing en_out, en_pwm and duty (40 bits).
REQ-014 SHALL run a prescaler 0..PRESCALE-1 that wraps to 0 and asserts an internal tick on its PRESCALE-1 cycle.
REQ-015 SHALL advance the 8-bit pwm_cnt by 1 on each tick, wrapping 255->0; a period is 256 ticks.
REQ-016 SHALL define the boundary as a tick with pwm_cnt==255.
REQ-017 SHALL compute pwm_level = 1 when active duty==8'hFF, else (pwm_cnt < active duty); duty 0 gives constant 0.
REQ-018 SHALL drive uo_out[i] = active en_out[i] ? (active en_pwm[i] ? pwm_level : 1) : 0, decoded only from registered state.
REQ-019 SHALL implement FSM states IDLE (nothing pending) and PENDING (pending set valid); cfg_pending = (state==PENDING).
REQ-020 SHALL, on cfg_valid with cfg_immediate=0: load pending from the inputs and go to PENDING from any state.
REQ-021 SHALL, in PENDING at the boundary: copy pending to active, go to IDLE, and pulse cfg_ack on the following cycle.
REQ-022 SHALL, on cfg_valid with cfg_immediate=1: load active directly from the inputs; clear prescaler and pwm_cnt to 0; go to IDLE (discarding any pending set); pulse cfg_ack on the following cycle.
REQ-023 SHALL, when cfg_valid (immediate=0) coincides with a PENDING boundary: commit the input values, not the older pending set; go to IDLE; pulse cfg_ack once.
REQ-024 SHALL let the latest cfg_valid overwrite the pending set while PENDING, with no cfg_ack for the overwritten set.
REQ-025 SHALL assert period_start on the cycle after the boundary and on the cycle after an immediate commit.
REQ-026 SHALL reflect a committed configuration on uo_out from the first cycle of the new period, or the cycle after an immediate commit.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE; prescaler, pwm_cnt, pending and active sets all 0; uo_out, cfg_ack, cfg_pending and period_start all 0.
REQ-028 SHALL discard any pending configuration and issue no cfg_ack if reset asserts mid-period or while PENDING.
REQ-029 SHALL leave the first period after reset release starting at pwm_cnt=0 with the prescaler at 0.

Verification
REQ-030 SHALL cover: PRESCALE=2; immediate cfg (en_out=16'h0001, en_pwm=16'h0001, duty=8'h80) -> cfg_ack after 1 cycle; uo_out[0] high for 256 clk and low for 256 clk per 512-clk period.
REQ-031 SHALL cover: deferred cfg (duty=8'h40) sent at pwm_cnt=10 -> cfg_pending=1 until the boundary; new duty takes effect at the next period_start; cfg_ack pulses exactly once.
REQ-032 SHALL cover: duty 8'h00 and 8'hFF with en_pwm=16'hFFFF, en_out=16'hFFFF -> uo_out constant 16'h0000 and 16'hFFFF respectively.
REQ-033 SHALL cover: two deferred cfgs in one period (duty 8'h10, then 8'h20), the second on the boundary cycle -> duty 8'h20 committed; one cfg_ack.
REQ-034 SHALL cover: en_out=16'hF00F, en_pwm=16'h000F -> uo_out[15:12]=1 constant, uo_out[3:0] PWM, other bits 0.
REQ-035 SHALL cover: rst_n low while PENDING -> all outputs 0, cfg_pending=0, no cfg_ack after release.
